sync_fifo_ctrl: RTL and testbench

Parametrised single-clock FIFO for buffering data inside one clock domain. It replaces hand-instantiated fixed 16x8 buffers with configurable width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush. A build-time mode selects show-ahead (first-word-fall-through) or registered read data.

---
 rtl/sync_fifo_ctrl.sv | 74 +++++++
 tb/tb_sync_fifo_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with occupancy count, almost flags, sticky errors and flush
module sync_fifo_ctrl #(
  parameter int data_bus_length = 8,
  parameter int address_bus_length = 4,
  parameter bit show_ahead = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          write_enable,
  input  logic [data_bus_length-1:0]    trans_data,
  input  logic                          read_enable,
  output logic [data_bus_length-1:0]    recv_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  input  logic [address_bus_length:0]   af_margin,
  input  logic [address_bus_length:0]   ae_margin,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [address_bus_length:0]   fifo_count,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int fifo_depth = 2 ** address_bus_length;
  logic [data_bus_length-1:0] mem [fifo_depth];
  logic [address_bus_length-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [address_bus_length:0] count_q, count_d;
  logic ovf_q, ovf_d, unf_q, unf_d, rd_acc, wr_acc;
  logic [data_bus_length-1:0] rdata_q;
  logic [address_bus_length+1:0] cnt_x, af_x, depth_x;
  // count never exceeds depth, so its MSB alone marks full
  assign fifo_full = count_q[address_bus_length];
  assign fifo_empty = count_q == '0;
  assign cnt_x = {1'b0, count_q};
  assign af_x = {1'b0, af_margin};
  assign depth_x = {2'b01, {address_bus_length{1'b0}}};
  assign fifo_almost_full = (af_x > depth_x) | (cnt_x >= depth_x - af_x);
  assign fifo_almost_empty = count_q <= ae_margin;
  assign fifo_count = count_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
  assign recv_data = show_ahead ? mem[rptr_q] : rdata_q;
  assign rd_acc = read_enable & ~fifo_empty;
  assign wr_acc = write_enable & (~fifo_full | rd_acc);
  always_comb begin
    wptr_d = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_acc ? rptr_q + 1'b1 : rptr_q;
    count_d = (wr_acc & ~rd_acc) ? count_q + 1'b1 : (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
    ovf_d = ovf_q | (write_enable & ~wr_acc);
    unf_d = unf_q | (read_enable & ~rd_acc);
  end
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (!flush && rd_acc) rdata_q <= mem[rptr_q];
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) mem[wptr_q] <= trans_data;
  end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed bench driving a show-ahead and a registered instance against a queue model
module tb_sync_fifo_ctrl;
  logic clk = 0, rst = 1, flush = 0, we = 0, re = 0, armed = 0;
  logic [7:0] wd = 0;
  logic [4:0] af = 5'd2, ae = 5'd3;
  logic [7:0] rdat [2];
  logic [4:0] cnt [2];
  logic full [2], emp [2], afo [2], aeo [2], ovf [2], unf [2];
  int checks = 0, errors = 0;
  logic [7:0] q [$];
  logic ovf_m = 0, unf_m = 0;
  logic [7:0] rreg_m = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.data_bus_length(8), .address_bus_length(4), .show_ahead(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .write_enable(we), .trans_data(wd), .read_enable(re),
    .recv_data(rdat[0]), .fifo_full(full[0]), .fifo_empty(emp[0]), .af_margin(af), .ae_margin(ae),
    .fifo_almost_full(afo[0]), .fifo_almost_empty(aeo[0]), .fifo_count(cnt[0]),
    .overflow(ovf[0]), .underflow(unf[0]));
  sync_fifo_ctrl #(.data_bus_length(8), .address_bus_length(4), .show_ahead(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .write_enable(we), .trans_data(wd), .read_enable(re),
    .recv_data(rdat[1]), .fifo_full(full[1]), .fifo_empty(emp[1]), .af_margin(af), .ae_margin(ae),
    .fifo_almost_full(afo[1]), .fifo_almost_empty(aeo[1]), .fifo_count(cnt[1]),
    .overflow(ovf[1]), .underflow(unf[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference behaviour: a queue of at most 16 words, pop before push
  always @(posedge clk) begin
    if (rst) begin
      q.delete(); ovf_m <= 0; unf_m <= 0; rreg_m <= 0;
    end else if (flush) begin
      q.delete(); ovf_m <= 0; unf_m <= 0;
    end else begin
      if (we && q.size() == 16 && !re) ovf_m <= 1;
      if (re && q.size() == 0) unf_m <= 1;
      if (re && q.size() != 0) begin
        rreg_m <= q[0];
        void'(q.pop_front());
      end
      if (we && q.size() < 16) q.push_back(wd);
    end
  end

  always @(negedge clk) if (armed) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("count%0d", k), 32'(cnt[k]), q.size());
      chk($sformatf("full%0d", k), 32'(full[k]), 32'(q.size() == 16));
      chk($sformatf("empty%0d", k), 32'(emp[k]), 32'(q.size() == 0));
      chk($sformatf("afull%0d", k), 32'(afo[k]), 32'(int'(af) > 16 || int'(q.size()) >= 16 - int'(af)));
      chk($sformatf("aempty%0d", k), 32'(aeo[k]), 32'(int'(q.size()) <= int'(ae)));
      chk($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(ovf_m));
      chk($sformatf("unf%0d", k), 32'(unf[k]), 32'(unf_m));
    end
    if (q.size() != 0) chk("rdata_sa", 32'(rdat[0]), 32'(q[0]));
    chk("rdata_reg", 32'(rdat[1]), 32'(rreg_m));
  end

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic f);
    we = w; wd = d; re = r; flush = f;
    @(posedge clk); #1;
    we = 0; re = 0; flush = 0;
  endtask

  task automatic do_rst();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0; armed = 1;
    chk("rst_empty", 32'(emp[0]), 1);
    chk("rst_full", 32'(full[0]), 0);
    chk("rst_aempty", 32'(aeo[0]), 1);
    chk("rst_rreg", 32'(rdat[1]), 0);
    // read on empty, then a write becomes visible next cycle
    cyc(0, 0, 1, 0);
    chk("unf_set", 32'(unf[0]), 1);
    chk("unf_count", 32'(cnt[0]), 0);
    cyc(1, 8'h55, 0, 0);
    chk("w55_data", 32'(rdat[0]), 32'h55);
    chk("w55_empty", 32'(emp[0]), 0);
    cyc(0, 0, 1, 0);
    chk("r55_reg", 32'(rdat[1]), 32'h55);
    chk("unf_sticky", 32'(unf[0]), 1);
    // fill with almost-flag tracking, overflow, drain
    do_rst();
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 8'(i), 0, 0);
      chk("fill_ae", 32'(aeo[0]), 32'(i <= 3));
      chk("fill_af", 32'(afo[0]), 32'(i >= 14));
    end
    chk("full16", 32'(full[0]), 1);
    chk("count16", 32'(cnt[0]), 16);
    cyc(1, 8'hAA, 0, 0);
    chk("ovf_set", 32'(ovf[0]), 1);
    chk("ovf_count", 32'(cnt[0]), 16);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_sa", 32'(rdat[0]), 32'(i));
      cyc(0, 0, 1, 0);
      chk("drain_reg", 32'(rdat[1]), 32'(i));
    end
    chk("drain_empty", 32'(emp[0]), 1);
    af = 5'd20; #1;
    chk("af20", 32'(afo[0]), 1);
    af = 5'd2;
    // write+read while full
    do_rst();
    for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'h77, 1, 0);
    chk("both_count", 32'(cnt[0]), 16);
    chk("both_ovf", 32'(ovf[0]), 0);
    for (int i = 2; i <= 17; i++) begin
      chk("both_sa", 32'(rdat[0]), i == 17 ? 32'h77 : 32'(i));
      cyc(0, 0, 1, 0);
    end
    // registered read latency and hold
    do_rst();
    cyc(1, 8'h3C, 0, 0);
    cyc(1, 8'hC3, 0, 0);
    cyc(0, 0, 1, 0);
    chk("reg_3c", 32'(rdat[1]), 32'h3C);
    cyc(0, 0, 1, 0);
    chk("reg_c3", 32'(rdat[1]), 32'hC3);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("reg_hold", 32'(rdat[1]), 32'hC3);
    // wrap then flush
    do_rst();
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    chk("wrap_count", 32'(cnt[0]), 12);
    chk("wrap_head", 32'(rdat[0]), 32'h20);
    chk("wrap_unf", 32'(unf[0]), 1);
    cyc(1, 8'hEE, 1, 1);
    chk("flush_count", 32'(cnt[0]), 0);
    chk("flush_empty", 32'(emp[0]), 1);
    chk("flush_ovf", 32'(ovf[0]), 0);
    chk("flush_unf", 32'(unf[0]), 0);
    chk("flush_reghold", 32'(rdat[1]), 32'h49);
    cyc(1, 8'h99, 0, 0);
    chk("post_flush", 32'(rdat[0]), 32'h99);
    chk("post_count", 32'(cnt[0]), 1);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
